// File: rtl/spi_regbank_pkg.sv
// Shared register addresses and default constants for the SPI register bank.
package spi_regbank_pkg;

  localparam logic [7:0] ADDR_ID         = 8'h00;
  localparam logic [7:0] ADDR_CTRL       = 8'h01;
  localparam logic [7:0] ADDR_GAIN       = 8'h02;
  localparam logic [7:0] ADDR_IRQ_STATUS = 8'h03;
  localparam logic [7:0] ADDR_IRQ_MASK   = 8'h04;
  localparam logic [7:0] ADDR_SCRATCH    = 8'h05;
  localparam logic [7:0] ADDR_WRCNT      = 8'h06;

  localparam logic [7:0] ID_DEFAULT   = 8'hA5;
  localparam logic [7:0] CTRL_DEFAULT = 8'h00;
  localparam logic [7:0] GAIN_DEFAULT = 8'h10;

endpackage

// File: rtl/spi_regbank_pulse_sync.sv
// Two-flop synchronizer for an asynchronous level, followed by a rising-edge
// detector that yields a single clk-cycle pulse per low-to-high transition.
module pulse_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic pulse
);

  logic s1_q, s2_q, s3_q;
  logic s1_d, s2_d, s3_d;

  // Shift chain: s1/s2 resolve metastability, s3 remembers the previous level.
  always_comb begin
    s1_d = async_in;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  // Synchronizer registers, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign pulse = s2_q & ~s3_q;

endmodule

// File: rtl/spi_regbank.sv
// Register bank behind the SPI slave: synchronized write strobe, config
// registers, sticky W1C interrupt status with mask, and a registered read port.
module spi_regbank
  import spi_regbank_pkg::*;
#(
  parameter logic [7:0] ID_VALUE = ID_DEFAULT,
  parameter logic [7:0] CTRL_RST = CTRL_DEFAULT,
  parameter logic [7:0] GAIN_RST = GAIN_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rf_addr,
  input  logic [7:0] rf_din,
  input  logic       wre,
  output logic [7:0] rf_dout,
  input  logic [7:0] irq_in,
  output logic [7:0] ctrl_out,
  output logic [7:0] gain_out,
  output logic       irq
);

  logic       wr_pulse;
  logic [7:0] ctrl_q, ctrl_d;
  logic [7:0] gain_q, gain_d;
  logic [7:0] irq_status_q, irq_status_d;
  logic [7:0] irq_mask_q, irq_mask_d;
  logic [7:0] scratch_q, scratch_d;
  logic [7:0] wr_count_q, wr_count_d;
  logic [7:0] rf_dout_q, rf_dout_d;
  logic       irq_q, irq_d;
  logic [7:0] clr_bits;

  pulse_sync u_wre_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (wre),
    .pulse    (wr_pulse)
  );

  // Next-state for all registers; address/data are sampled only on wr_pulse,
  // by which time the sclk-domain bus has long been stable.
  always_comb begin
    ctrl_d     = ctrl_q;
    gain_d     = gain_q;
    irq_mask_d = irq_mask_q;
    scratch_d  = scratch_q;
    wr_count_d = wr_count_q;
    clr_bits   = 8'h00;
    if (wr_pulse) begin
      // Every accepted write counts, including unmapped and read-only targets.
      wr_count_d = wr_count_q + 8'd1;
      case (rf_addr)
        ADDR_CTRL:       ctrl_d     = rf_din;
        ADDR_GAIN:       gain_d     = rf_din;
        ADDR_IRQ_STATUS: clr_bits   = rf_din;
        ADDR_IRQ_MASK:   irq_mask_d = rf_din;
        ADDR_SCRATCH:    scratch_d  = rf_din;
        default:         ;
      endcase
    end
    // Set is OR-ed in after the clear so a same-cycle event is never lost.
    irq_status_d = (irq_status_q & ~clr_bits) | irq_in;
    irq_d        = |(irq_status_d & irq_mask_d);

    case (rf_addr)
      ADDR_ID:         rf_dout_d = ID_VALUE;
      ADDR_CTRL:       rf_dout_d = ctrl_q;
      ADDR_GAIN:       rf_dout_d = gain_q;
      ADDR_IRQ_STATUS: rf_dout_d = irq_status_q;
      ADDR_IRQ_MASK:   rf_dout_d = irq_mask_q;
      ADDR_SCRATCH:    rf_dout_d = scratch_q;
      ADDR_WRCNT:      rf_dout_d = wr_count_q;
      default:         rf_dout_d = 8'h00;
    endcase
  end

  // Register storage with synchronous reset to the documented defaults.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q       <= CTRL_RST;
      gain_q       <= GAIN_RST;
      irq_status_q <= 8'h00;
      irq_mask_q   <= 8'h00;
      scratch_q    <= 8'h00;
      wr_count_q   <= 8'h00;
      rf_dout_q    <= 8'h00;
      irq_q        <= 1'b0;
    end else begin
      ctrl_q       <= ctrl_d;
      gain_q       <= gain_d;
      irq_status_q <= irq_status_d;
      irq_mask_q   <= irq_mask_d;
      scratch_q    <= scratch_d;
      wr_count_q   <= wr_count_d;
      rf_dout_q    <= rf_dout_d;
      irq_q        <= irq_d;
    end
  end

  assign rf_dout  = rf_dout_q;
  assign ctrl_out = ctrl_q;
  assign gain_out = gain_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_spi_regbank.sv
// Directed bench for spi_regbank: reset defaults, held/burst writes, W1C
// interrupt behaviour, counter wrap and reset in the middle of a write.
module tb_spi_regbank;

  logic       clk;
  logic       rst;
  logic [7:0] rf_addr;
  logic [7:0] rf_din;
  logic       wre;
  logic [7:0] rf_dout;
  logic [7:0] irq_in;
  logic [7:0] ctrl_out;
  logic [7:0] gain_out;
  logic       irq;

  int n_vec;
  int n_miss;

  spi_regbank dut (
    .clk      (clk),
    .rst      (rst),
    .rf_addr  (rf_addr),
    .rf_din   (rf_din),
    .wre      (wre),
    .rf_dout  (rf_dout),
    .irq_in   (irq_in),
    .ctrl_out (ctrl_out),
    .gain_out (gain_out),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_vec(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [7:0] addr, input logic [7:0] exp, input string tag);
    rf_addr = addr;
    tick();
    check_vec(tag, rf_dout, exp);
  endtask

  task automatic wr(input logic [7:0] addr, input logic [7:0] data, input int hi, input int lo);
    rf_addr = addr;
    rf_din  = data;
    wre     = 1'b1;
    repeat (hi) tick();
    wre = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  initial begin
    n_vec   = 0;
    n_miss  = 0;
    rst     = 1'b0;
    rf_addr = 8'h00;
    rf_din  = 8'h00;
    wre     = 1'b0;
    irq_in  = 8'h00;
    tick();

    // 1: reset defaults
    do_reset();
    check_vec("rst_dout", rf_dout, 8'h00);
    check_vec("rst_irq", {7'd0, irq}, 8'h00);
    check_vec("rst_ctrl", ctrl_out, 8'h00);
    check_vec("rst_gain", gain_out, 8'h10);
    rd(8'h00, 8'hA5, "id");
    rd(8'h02, 8'h10, "gain_rd");

    // 2: single write with wre held high
    rf_addr = 8'h01;
    rf_din  = 8'h3C;
    wre     = 1'b1;
    repeat (3) tick();
    check_vec("ctrl_3clk", ctrl_out, 8'h3C);
    repeat (37) tick();
    wre = 1'b0;
    repeat (4) tick();
    rd(8'h06, 8'h01, "wrcnt_held");
    rd(8'h01, 8'h3C, "ctrl_rd");

    // 3: burst-style writes from a fresh reset
    do_reset();
    wr(8'h04, 8'hFF, 8, 56);
    wr(8'h05, 8'h5A, 8, 56);
    wr(8'h07, 8'h77, 8, 56);
    rd(8'h04, 8'hFF, "mask");
    rd(8'h05, 8'h5A, "scratch");
    rd(8'h07, 8'h00, "unmapped");
    rd(8'h06, 8'h03, "wrcnt_burst");
    check_vec("ctrl_untouched", ctrl_out, 8'h00);

    // 4: interrupt set, W1C clear, set/clear collision
    rf_addr = 8'h03;
    check_vec("irq_idle", {7'd0, irq}, 8'h00);
    irq_in = 8'h04;
    tick();
    irq_in = 8'h00;
    check_vec("irq_set", {7'd0, irq}, 8'h01);
    rd(8'h03, 8'h04, "status_set");
    wr(8'h03, 8'h04, 8, 8);
    rd(8'h03, 8'h00, "status_clr");
    check_vec("irq_clr", {7'd0, irq}, 8'h00);
    rf_addr = 8'h03;
    rf_din  = 8'h04;
    wre     = 1'b1;
    tick();
    tick();
    irq_in = 8'h04;
    tick();
    irq_in = 8'h00;
    repeat (5) tick();
    wre = 1'b0;
    repeat (4) tick();
    rd(8'h03, 8'h04, "status_collide");
    check_vec("irq_collide", {7'd0, irq}, 8'h01);
    // masking off the source drops irq while status stays sticky
    wr(8'h04, 8'h00, 8, 4);
    check_vec("irq_masked", {7'd0, irq}, 8'h00);
    rd(8'h03, 8'h04, "status_sticky");
    // write to read-only WR_COUNT still counts: 3 + 2 + 1 + 1 = 7
    wr(8'h06, 8'h80, 8, 8);
    rd(8'h06, 8'h07, "wrcnt_ro");

    // 5: counter wrap
    do_reset();
    for (int i = 0; i < 256; i++) wr(8'h05, i[7:0], 4, 4);
    rd(8'h06, 8'h00, "wrcnt_wrap");
    rd(8'h05, 8'hFF, "scratch_last");
    wr(8'h05, 8'h11, 4, 4);
    rd(8'h06, 8'h01, "wrcnt_after_wrap");

    // 6: reset during a write with wre still high afterwards
    wr(8'h01, 8'h55, 4, 4);
    check_vec("ctrl_pre", ctrl_out, 8'h55);
    rf_addr = 8'h05;
    rf_din  = 8'hAA;
    wre     = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_vec("mid_ctrl", ctrl_out, 8'h00);
    check_vec("mid_gain", gain_out, 8'h10);
    repeat (10) tick();
    wre = 1'b0;
    repeat (4) tick();
    rd(8'h06, 8'h01, "mid_wrcnt");
    rd(8'h05, 8'hAA, "mid_scratch");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
